// File: rtl/odd_fwd_stage_pipe.sv
// odd_fwd_stage_pipe: odd-side result staging chain with per-unit injection, flush,
// collision tracking, operand forwarding and a registered writeback port.
module odd_fwd_stage_pipe #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int DEPTH = 7,
    parameter int NUM_UNITS = 3,
    parameter logic [4*NUM_UNITS-1:0] UNIT_STAGE = 12'h641,
    parameter int NUM_SRC = 3,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_UNITS-1:0]        unit_wr,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
    input  logic [NUM_UNITS*ADDR_W-1:0] unit_addr,
    input  logic                        flush,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
    output logic [NUM_SRC-1:0]          fwd_hit,
    output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
    output logic [DEPTH*DATA_W-1:0]     stage_data,
    output logic [DEPTH*ADDR_W-1:0]     stage_addr,
    output logic [DEPTH-1:0]            stage_wr,
    output logic [DATA_W-1:0]           rt_wb,
    output logic [ADDR_W-1:0]           rt_addr_wb,
    output logic                        reg_write_wb,
    output logic                        collision_err,
    output logic [CNT_W-1:0]            collision_cnt
);
    logic [DATA_W-1:0] s_data [1:DEPTH];
    logic [DATA_W-1:0] n_data [1:DEPTH];
    logic [ADDR_W-1:0] s_addr [1:DEPTH];
    logic [ADDR_W-1:0] n_addr [1:DEPTH];
    logic [DEPTH:1] s_wr, n_wr, drop;

    for (genvar i = 0; i < NUM_UNITS; i++) begin : g_chk
        if (int'(UNIT_STAGE[4*i +: 4]) == 0 || int'(UNIT_STAGE[4*i +: 4]) > DEPTH) begin : g_bad
            $error("odd_fwd_stage_pipe: unit %0d injection stage out of range", i);
        end
    end

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        logic [DATA_W-1:0] pd, d;
        logic [ADDR_W-1:0] pa, a;
        logic pw, w, kill, hit, dr;
        if (k == 1) begin : g_head
            assign pd = '0;
            assign pa = '0;
            assign pw = 1'b0;
        end else begin : g_body
            assign pd = s_data[k-1];
            assign pa = s_addr[k-1];
            assign pw = s_wr[k-1];
        end
        assign kill = flush && (k <= FLUSH_DEPTH);
        // lowest unit index wins; any losing unit or overwritten valid entry is a drop
        always_comb begin
            d = pd;
            a = pa;
            w = pw && !kill;
            hit = 1'b0;
            dr = 1'b0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (unit_wr[i] && !kill && UNIT_STAGE[4*i +: 4] == 4'(k)) begin
                    dr = dr || hit || pw;
                    if (!hit) begin
                        d = unit_data[i*DATA_W +: DATA_W];
                        a = unit_addr[i*ADDR_W +: ADDR_W];
                        w = 1'b1;
                    end
                    hit = 1'b1;
                end
            end
        end
        assign n_data[k] = d;
        assign n_addr[k] = a;
        assign n_wr[k] = w;
        assign drop[k] = dr;
        assign stage_data[(k-1)*DATA_W +: DATA_W] = s_data[k];
        assign stage_addr[(k-1)*ADDR_W +: ADDR_W] = s_addr[k];
    end
    assign stage_wr = s_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                s_data[k] <= '0;
                s_addr[k] <= '0;
            end
            s_wr <= '0;
            rt_wb <= '0;
            rt_addr_wb <= '0;
            reg_write_wb <= 1'b0;
            collision_err <= 1'b0;
            collision_cnt <= '0;
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                s_data[k] <= n_data[k];
                s_addr[k] <= n_addr[k];
            end
            s_wr <= n_wr;
            rt_wb <= s_data[DEPTH];
            rt_addr_wb <= s_addr[DEPTH];
            reg_write_wb <= s_wr[DEPTH];
            collision_err <= collision_err || (|drop);
            if ((|drop) && !(&collision_cnt)) collision_cnt <= collision_cnt + 1'b1;
        end
    end

    // writeback register first, then stages oldest to youngest so the youngest match wins
    always_comb begin
        fwd_hit = '0;
        fwd_data = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (src_valid[j] && reg_write_wb && rt_addr_wb == src_addr[j*ADDR_W +: ADDR_W]) begin
                fwd_hit[j] = 1'b1;
                fwd_data[j*DATA_W +: DATA_W] = rt_wb;
            end
            for (int k = DEPTH; k >= 1; k--) begin
                if (src_valid[j] && s_wr[k] && s_addr[k] == src_addr[j*ADDR_W +: ADDR_W]) begin
                    fwd_hit[j] = 1'b1;
                    fwd_data[j*DATA_W +: DATA_W] = s_data[k];
                end
            end
        end
    end
endmodule
